// File: rtl/ex_operand_stage.sv
// Execute-stage input register: resolves forwarding and operand select at capture
// and holds ops in a two-entry (main + skid) buffer that feeds the ALU.
module ex_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_alu_sel,
  input  logic [1:0]       in_op1_sel,
  input  logic             in_op2_imm,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [WIDTH-1:0] in_rs1_val,
  input  logic [WIDTH-1:0] in_rs2_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_rd_we,
  input  logic             fwd_exmem_we,
  input  logic [4:0]       fwd_exmem_rd,
  input  logic [WIDTH-1:0] fwd_exmem_data,
  input  logic             fwd_memwb_we,
  input  logic [4:0]       fwd_memwb_rd,
  input  logic [WIDTH-1:0] fwd_memwb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [4:0]       alu_sel,
  output logic [WIDTH-1:0] out_pc,
  output logic [4:0]       out_rd_addr,
  output logic             out_rd_we
);

  typedef struct packed {
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic [4:0]       sel;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rd_addr;
    logic             rd_we;
  } entry_t;

  entry_t     main_q, skid_q, in_entry;
  logic       main_valid, skid_valid;
  logic       in_fire, out_fire;
  logic [WIDTH-1:0] rs1_fwd, rs2_fwd;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  // x0 is hard-wired zero, so it is never a forwarding target; EX/MEM is the younger result.
  always_comb begin
    rs1_fwd = in_rs1_val;
    if (in_rs1_addr != '0 && fwd_exmem_we && fwd_exmem_rd == in_rs1_addr)
      rs1_fwd = fwd_exmem_data;
    else if (in_rs1_addr != '0 && fwd_memwb_we && fwd_memwb_rd == in_rs1_addr)
      rs1_fwd = fwd_memwb_data;

    rs2_fwd = in_rs2_val;
    if (in_rs2_addr != '0 && fwd_exmem_we && fwd_exmem_rd == in_rs2_addr)
      rs2_fwd = fwd_exmem_data;
    else if (in_rs2_addr != '0 && fwd_memwb_we && fwd_memwb_rd == in_rs2_addr)
      rs2_fwd = fwd_memwb_data;
  end

  always_comb begin
    in_entry = '0;
    case (in_op1_sel)
      2'd0:    in_entry.op0 = rs1_fwd;
      2'd1:    in_entry.op0 = in_pc;
      default: in_entry.op0 = '0;
    endcase
    in_entry.op1     = in_op2_imm ? in_imm : rs2_fwd;
    in_entry.sel     = in_alu_sel;
    in_entry.pc      = in_pc;
    in_entry.rd_addr = in_rd_addr;
    in_entry.rd_we   = in_rd_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end
    end else if (out_fire) begin
      // in_ready is low whenever skid holds an op, so the skid drain never races an accept.
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q <= in_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign alu_in0     = main_q.op0;
  assign alu_in1     = main_q.op1;
  assign alu_sel     = main_q.sel;
  assign out_pc      = main_q.pc;
  assign out_rd_addr = main_q.rd_addr;
  assign out_rd_we   = main_q.rd_we;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for forwarding/operand select,
// hand sequences for backpressure, flush and asynchronous reset.
module tb_ex_operand_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [4:0]    in_alu_sel;
  logic [1:0]    in_op1_sel;
  logic          in_op2_imm;
  logic [4:0]    in_rs1_addr, in_rs2_addr;
  logic [W-1:0]  in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic [4:0]    in_rd_addr;
  logic          in_rd_we;
  logic          fwd_exmem_we, fwd_memwb_we;
  logic [4:0]    fwd_exmem_rd, fwd_memwb_rd;
  logic [W-1:0]  fwd_exmem_data, fwd_memwb_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  alu_in0, alu_in1, out_pc;
  logic [4:0]    alu_sel, out_rd_addr;
  logic          out_rd_we;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_sel(in_alu_sel), .in_op1_sel(in_op1_sel), .in_op2_imm(in_op2_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .fwd_exmem_we(fwd_exmem_we), .fwd_exmem_rd(fwd_exmem_rd), .fwd_exmem_data(fwd_exmem_data),
    .fwd_memwb_we(fwd_memwb_we), .fwd_memwb_rd(fwd_memwb_rd), .fwd_memwb_data(fwd_memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel),
    .out_pc(out_pc), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
  );

  typedef struct {
    logic [4:0]   sel;
    logic [1:0]   op1_sel;
    logic         op2_imm;
    logic [4:0]   rs1a, rs2a;
    logic [W-1:0] rs1v, rs2v, imm, pc;
    logic [4:0]   rd;
    logic         we;
    logic         ewe;
    logic [4:0]   erd;
    logic [W-1:0] edata;
    logic         mwe;
    logic [4:0]   mrd;
    logic [W-1:0] mdata;
    logic [W-1:0] exp0, exp1;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v, input logic valid);
    in_valid       = valid;
    in_alu_sel     = v.sel;
    in_op1_sel     = v.op1_sel;
    in_op2_imm     = v.op2_imm;
    in_rs1_addr    = v.rs1a;
    in_rs2_addr    = v.rs2a;
    in_rs1_val     = v.rs1v;
    in_rs2_val     = v.rs2v;
    in_imm         = v.imm;
    in_pc          = v.pc;
    in_rd_addr     = v.rd;
    in_rd_we       = v.we;
    fwd_exmem_we   = v.ewe;
    fwd_exmem_rd   = v.erd;
    fwd_exmem_data = v.edata;
    fwd_memwb_we   = v.mwe;
    fwd_memwb_rd   = v.mrd;
    fwd_memwb_data = v.mdata;
  endtask

  // Plain rs1 + rs2 op, no forwarding; alu_in0 carries the tag to identify ordering.
  function automatic vec_t simple(input logic [W-1:0] tag);
    vec_t v;
    v = '{5'd0, 2'd0, 1'b0, 5'd1, 5'd2, tag, tag + 32'd1, 32'd0, 32'h400 + tag,
          5'd9, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, tag, tag + 32'd1};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    // sel op1 imm? rs1a rs2a rs1v rs2v imm pc rd we | exmem we/rd/data | memwb we/rd/data | exp0 exp1
    vecs[0] = '{5'd0, 2'd0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'h10, 5'd3, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7};
    vecs[1] = '{5'd1, 2'd0, 1'b0, 5'd3, 5'd4, 32'h33, 32'h44, 32'd0, 32'h14, 5'd5, 1'b1,
                1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'h44};
    vecs[2] = '{5'd2, 2'd0, 1'b0, 5'd0, 5'd0, 32'h11, 32'h22, 32'd0, 32'h18, 5'd6, 1'b0,
                1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h11, 32'h22};
    vecs[3] = '{5'd3, 2'd2, 1'b1, 5'd7, 5'd8, 32'h77, 32'h88, 32'h12345000, 32'h1C, 5'd7, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'h12345000};
    vecs[4] = '{5'd0, 2'd1, 1'b1, 5'd7, 5'd8, 32'h77, 32'h88, 32'h2000, 32'h100, 5'd8, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h100, 32'h2000};
    vecs[5] = '{5'd4, 2'd3, 1'b0, 5'd1, 5'd2, 32'h55, 32'h66, 32'd0, 32'h20, 5'd10, 1'b0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'h66};
    vecs[6] = '{5'd5, 2'd0, 1'b0, 5'd5, 5'd5, 32'h51, 32'h52, 32'd0, 32'h24, 5'd11, 1'b1,
                1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 32'hBB, 32'hBB};
    vecs[7] = '{5'd6, 2'd0, 1'b0, 5'd9, 5'd6, 32'h91, 32'h92, 32'd0, 32'h28, 5'd12, 1'b1,
                1'b1, 5'd6, 32'hCC, 1'b1, 5'd9, 32'hDD, 32'hDD, 32'hCC};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(simple(32'd0), 1'b0);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_alu_in0", alu_in0, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Back-to-back stream: each vector is emitted the cycle after it is accepted.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i], 1'b1);
      tick();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_alu_in0", i), alu_in0, vecs[i].exp0);
      chk($sformatf("v%0d_alu_in1", i), alu_in1, vecs[i].exp1);
      chk($sformatf("v%0d_alu_sel", i), {27'd0, alu_sel}, {27'd0, vecs[i].sel});
      chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
      chk($sformatf("v%0d_rd_addr", i), {27'd0, out_rd_addr}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_rd_we", i), {31'd0, out_rd_we}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    drive(simple(32'd0), 1'b0);
    tick();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A in main, B in skid, C held upstream until space appears.
    @(negedge clk); out_ready = 1'b0; drive(simple(32'hA0), 1'b1);
    tick();
    chk("bp_a_in0", alu_in0, 32'hA0);
    @(negedge clk); drive(simple(32'hB0), 1'b1);
    tick();
    chk("bp_skid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_a_stable1", alu_in0, 32'hA0);
    @(negedge clk); drive(simple(32'hC0), 1'b1);
    tick();
    chk("bp_a_stable2", alu_in0, 32'hA0);
    chk("bp_a_stable_in1", alu_in1, 32'hA1);
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk); out_ready = 1'b1;
    tick();
    chk("bp_b_in0", alu_in0, 32'hB0);
    chk("bp_b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_c_in0", alu_in0, 32'hC0);
    chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk); drive(simple(32'd0), 1'b0);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and an op presented.
    @(negedge clk); out_ready = 1'b0; drive(simple(32'h10), 1'b1);
    tick();
    @(negedge clk); drive(simple(32'h20), 1'b1);
    tick();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk); flush = 1'b1; drive(simple(32'h30), 1'b1);
    tick();
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); flush = 1'b0; drive(simple(32'd0), 1'b0); out_ready = 1'b1;
    tick();
    chk("fl_no_emit", {31'd0, out_valid}, 32'd0);

    // Flush while an accept actually fires: that op is discarded too.
    @(negedge clk); flush = 1'b1; drive(simple(32'h40), 1'b1);
    tick();
    @(negedge clk); flush = 1'b0; drive(simple(32'd0), 1'b0);
    tick();
    chk("fl_fire_discard", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle with main full.
    @(negedge clk); out_ready = 1'b0; drive(simple(32'h55), 1'b1);
    tick();
    @(negedge clk); drive(simple(32'h66), 1'b1);
    tick();
    chk("ar_pre_in0", alu_in0, 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_alu_in0", alu_in0, 32'd0);
    chk("ar_alu_in1", alu_in1, 32'd0);
    chk("ar_out_pc", out_pc, 32'd0);
    chk("ar_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0; drive(simple(32'd0), 1'b0); out_ready = 1'b1;
    tick();
    chk("ar_after", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Execute-stage input register between instruction decode and the ALU.
- Accepts decoded micro-ops over a valid/ready handshake and resolves register operands with EX/MEM and MEM/WB forwarding at capture time.
- Selects ALU operands (rs1/pc/zero, rs2/imm) and presents a registered, stable operand pair plus ALU select to the combinational ALU.
- A 2-entry skid buffer (main + skid) keeps in_ready fully registered and sustains one op/cycle when downstream is ready.

Parameters:
- WIDTH, 32, datapath width of operands, immediates, pc and forwarded data.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held ops (branch mispredict/trap)
- in_valid  in  1  decode presents an op
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered)
- in_alu_sel  in  5  ALU operation code (alu_pkg encoding)
- in_op1_sel  in  2  0=rs1, 1=pc, 2=zero, 3=zero
- in_op2_imm  in  1  1=immediate, 0=rs2
- in_rs1_addr, in_rs2_addr  in  5 each  source register indices
- in_rs1_val, in_rs2_val  in  WIDTH each  register-file read data
- in_imm  in  WIDTH  sign/shift-extended immediate
- in_pc  in  WIDTH  instruction pc
- in_rd_addr  in  5  destination register
- in_rd_we  in  1  destination write enable
- fwd_exmem_we, fwd_exmem_rd, fwd_exmem_data  in  1/5/WIDTH  EX/MEM forward source
- fwd_memwb_we, fwd_memwb_rd, fwd_memwb_data  in  1/5/WIDTH  MEM/WB forward source
- out_valid  out  1  operands valid to ALU
- out_ready  in  1  downstream consumes this cycle
- alu_in0, alu_in1  out  WIDTH each  ALU operands
- alu_sel  out  5  ALU operation code
- out_pc  out  WIDTH  pc of held op
- out_rd_addr  out  5  destination register
- out_rd_we  out  1  destination write enable

Behaviour:
- Reset (async, rst=1): main_valid=0, skid_valid=0, all output data regs 0; out_valid=0, in_ready=1 while and after reset. Reset mid-operation discards held ops.
- Accept: in_fire = in_valid & in_ready. Emit: out_fire = out_valid & out_ready. out_valid = main_valid. Outputs are driven from the main entry only.
- Forwarding, computed combinationally on in_* at capture: for each rsN, if rsN_addr!=0 & fwd_exmem_we & fwd_exmem_rd==rsN_addr use fwd_exmem_data; else if the same test holds for MEM/WB use fwd_memwb_data; else use rsN_val. x0 is never forwarded; EX/MEM has priority.
- Operand select at capture: op0 = rs1_fwd / in_pc / 0 per in_op1_sel; op1 = in_op2_imm ? in_imm : rs2_fwd. The stored entry holds {op0, op1, sel, pc, rd_addr, rd_we}. Forwarded values are frozen once captured.
- Per-cycle update, priority top-down:
  - flush=1: main_valid and skid_valid go to 0 next edge; any in_fire that cycle is discarded; in_ready=1 next cycle.
  - main empty: in_fire loads main.
  - main full, out_fire, skid empty: in_fire loads main, else main_valid goes to 0.
  - main full, out_fire, skid full: skid moves to main, skid_valid goes to 0. No accept is possible since in_ready=0.
  - main full, no out_fire: in_fire loads skid (skid_valid goes to 1).
- Ordering is strict FIFO. No op is dropped or duplicated except by flush/rst. Output data is stable while out_valid & !out_ready.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 op/cycle with out_ready held high.
- Combinational paths: in_ready depends only on state; there is no in→out comb path.

Test Plan:
- Reset then in_valid=1, sel=add, op1_sel=0, rs1_val=5, op2_imm=0, rs2_val=7, out_ready=1 -> next cycle out_valid=1, alu_in0=5, alu_in1=7, alu_sel=add; stream of 4 back-to-back ops emits 4 in order, in_ready stays 1.
- Forwarding: rs1_addr=3, exmem_we=1/rd=3/data=0xAA, memwb_we=1/rd=3/data=0xBB -> alu_in0=0xAA; with rs1_addr=0 and both forwards to rd=0 -> alu_in0=rs1_val.
- Operand select: lui-style op1_sel=2, op2_imm=1, imm=0x12345000 -> alu_in0=0, alu_in1=0x12345000; auipc op1_sel=1, pc=0x100 -> alu_in0=0x100.
- Backpressure: out_ready=0, push ops A, B -> B lands in skid, in_ready=0, C held upstream; out_ready=1 -> A, B, C emitted in order, A's outputs stable during stall.
- Flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle input is not emitted.
- Assert rst while main full -> out_valid=0 immediately (async), all outputs 0, in_ready=1.
